// File: rtl/com_tx_queue.sv
// com_tx_queue: byte FIFO that feeds a UART transmitter, with an inter-byte gap, a stall watchdog and a sent counter
module com_tx_queue #(
  parameter int DEPTH_LOG   = 4,
  parameter int GAP_CYCLES  = 0,
  parameter int STALL_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [7:0]         push_data,
  output logic               full,
  output logic               empty,
  output logic [DEPTH_LOG:0] count,
  output logic               TxD_start,
  output logic [7:0]         TxD_data,
  input  logic               TxD_busy,
  output logic               sent,
  output logic [15:0]        sent_count,
  output logic               overflow,
  output logic               tx_stall
);
  localparam int CW = DEPTH_LOG + 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;
  localparam state_t AFTER = GAP_CYCLES > 0 ? GAP : IDLE;
  logic [7:0] mem [2**DEPTH_LOG];
  logic [DEPTH_LOG-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  state_t state_q, state_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [GW-1:0] gap_q, gap_d;
  logic txd_start_q, txd_start_d, sent_q, sent_d, overflow_q, overflow_d, tx_stall_q, tx_stall_d;
  logic [7:0] txd_data_q, txd_data_d;
  logic [15:0] sent_count_q, sent_count_d;
  logic push_ok, pop;
  assign full = count_q == CW'(2**DEPTH_LOG);
  assign empty = count_q == '0;
  assign count = count_q;
  assign TxD_start = txd_start_q;
  assign TxD_data = txd_data_q;
  assign sent = sent_q;
  assign sent_count = sent_count_q;
  assign overflow = overflow_q;
  assign tx_stall = tx_stall_q;
  // queue bookkeeping and sequencer next state; pops only from IDLE with the transmitter free
  always_comb begin
    push_ok = push && !full;
    pop = state_q == IDLE && !empty && !TxD_busy;
    wr_d = wr_q + DEPTH_LOG'(push_ok);
    rd_d = rd_q + DEPTH_LOG'(pop);
    count_d = count_q + CW'(push_ok) - CW'(pop);
    txd_start_d = pop;
    txd_data_d = pop ? mem[rd_q] : txd_data_q;
    overflow_d = overflow_q | (push & full);
    state_d = state_q;
    stall_d = stall_q;
    gap_d = gap_q;
    sent_d = 1'b0;
    sent_count_d = sent_count_q;
    tx_stall_d = tx_stall_q;
    unique case (state_q)
      IDLE: begin
        state_d = pop ? WAIT_BUSY : IDLE;
        stall_d = pop ? '0 : stall_q;
      end
      WAIT_BUSY: begin
        state_d = TxD_busy ? WAIT_DONE : (stall_q == STALL_LAST ? AFTER : WAIT_BUSY);
        stall_d = TxD_busy || stall_q == STALL_LAST ? stall_q : stall_q + 1'b1;
        tx_stall_d = tx_stall_q | (!TxD_busy && stall_q == STALL_LAST);
        gap_d = '0;
      end
      WAIT_DONE: begin
        state_d = TxD_busy ? WAIT_DONE : AFTER;
        sent_d = !TxD_busy;
        sent_count_d = sent_count_q + 16'(!TxD_busy);
        gap_d = '0;
      end
      GAP: begin
        state_d = gap_q == GAP_LAST ? IDLE : GAP;
        gap_d = gap_q + 1'b1;
      end
    endcase
  end
  // byte storage; contents need no reset since the pointers are cleared
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= push_data;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      state_q <= IDLE;
      stall_q <= '0;
      gap_q <= '0;
      txd_start_q <= 1'b0;
      txd_data_q <= 8'h00;
      sent_q <= 1'b0;
      sent_count_q <= '0;
      overflow_q <= 1'b0;
      tx_stall_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      state_q <= state_d;
      stall_q <= stall_d;
      gap_q <= gap_d;
      txd_start_q <= txd_start_d;
      txd_data_q <= txd_data_d;
      sent_q <= sent_d;
      sent_count_q <= sent_count_d;
      overflow_q <= overflow_d;
      tx_stall_q <= tx_stall_d;
    end
  end
endmodule

// File: doc/com_tx_queue.md
# com_tx_queue

Byte queue with transmit sequencer that sits directly upstream of `uart_async_transmitter` on the simulation host side of the COM link. It buffers bytes pushed by the bench or a script player and issues them one at a time over the transmitter's `TxD_start`/`TxD_data`/`TxD_busy` handshake. An optional inter-byte idle gap is inserted between bytes. It also provides a stall watchdog and a completed-byte counter, so benches can stream multi-byte commands into `system`'s `com_RxD` without hand-timing each byte.

## Interface
- `DEPTH_LOG`, 4: queue depth is 2^DEPTH_LOG bytes.
- `GAP_CYCLES`, 0: idle clk cycles inserted after each completed byte; 0 disables the gap.
- `STALL_LIMIT`, 4: cycles to wait for `TxD_busy` to rise after a start before declaring a stall.

Ports:
- `clk` in 1: the single clock; all logic runs on its rising edge (same `clk` that drives the transmitter).
- `rst` in 1: synchronous, active-high reset.
- `push` in 1: write `push_data` into the queue this cycle.
- `push_data` in 8: byte to enqueue.
- `full` out 1: the queue holds 2^DEPTH_LOG bytes.
- `empty` out 1: the queue holds 0 bytes.
- `count` out DEPTH_LOG+1: current occupancy.
- `TxD_start` out 1: one-cycle start strobe to the transmitter.
- `TxD_data` out 8: byte presented with `TxD_start`; held stable until the next pop.
- `TxD_busy` in 1: transmitter busy flag.
- `sent` out 1: one-cycle pulse when a byte's transmission completes.
- `sent_count` out 16: number of completed bytes; wraps from 0xFFFF to 0.
- `overflow` out 1: sticky; set when a push is dropped.
- `tx_stall` out 1: sticky; set on a watchdog timeout.

## Operation
- Storage: 2^DEPTH_LOG x 8 array with read and write pointers of DEPTH_LOG bits, which wrap modulo depth. `count` is registered. `full` and `empty` decode from the registered `count`.
- Push: accepted only when `full` is 0. Writes `mem[wr]`, increments `wr`, and increments `count`.
- Push while `full`: the byte is dropped and `overflow` is set to 1. This holds even if a pop occurs in the same cycle, because `full` is the pre-edge value.
- Simultaneous accepted push and pop: `count` is unchanged and both pointers advance.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
  - IDLE: when `empty`=0 and `TxD_busy`=0, pop. The pop loads `TxD_data`=`mem[rd]`, increments `rd`, decrements `count`, and sets `TxD_start`=1. Then go to WAIT_BUSY and clear the stall counter. Otherwise stay in IDLE.
  - WAIT_BUSY: `TxD_start` returns to 0 at the next edge.
    - If `TxD_busy`=1, go to WAIT_DONE.
    - Otherwise increment the stall counter. When it reaches STALL_LIMIT, set `tx_stall`=1 and go to GAP, or to IDLE if GAP_CYCLES=0. The byte counts as lost: no `sent` pulse and no `sent_count` increment.
  - WAIT_DONE: when `TxD_busy`=0, pulse `sent` and increment `sent_count`. Then go to GAP, or to IDLE if GAP_CYCLES=0.
  - GAP: count exactly GAP_CYCLES cycles, then return to IDLE. Pops are not allowed while in GAP.
- `overflow` and `tx_stall` clear only on `rst`.

## Timing
- Reset values:
  - Pointers and `count` are 0.
  - `empty`=1, `full`=0.
  - `TxD_start`=0, `TxD_data`=0x00.
  - `sent`=0, `sent_count`=0.
  - `overflow`=0, `tx_stall`=0.
  - FSM is in IDLE; stall and gap counters are 0.
- Push-to-start latency, with the queue empty and the transmitter idle:
  - The push is sampled at edge E0.
  - `count`=1 is visible after E0.
  - The pop happens at E1, so `TxD_start` is high for exactly the cycle after E1.
  - Total: 2 cycles.
- `TxD_start` is never high for two consecutive cycles.
- `TxD_start` is never asserted while `TxD_busy` is sampled 1.
- `sent` is high for the cycle after the edge at which WAIT_DONE samples `TxD_busy`=0.
- Back-to-back bytes with GAP_CYCLES=0: the next `TxD_start` is asserted 1 cycle after `sent`, from IDLE.
- Back-to-back bytes with GAP_CYCLES=N: the next `TxD_start` is asserted N+1 cycles after `sent`.
- Reset mid-operation:
  - All state clears at that edge, and queued bytes are discarded.
  - `TxD_start` is 0 from the next cycle.
  - A transmission already in flight inside the transmitter is not aborted. The queue waits in IDLE until `TxD_busy`=0.
- Pointer wrap-around is transparent: byte order is strictly FIFO.

## Test plan
- Single byte, GAP_CYCLES=0:
  - Stimulus: push 0xA5 at E0 into an idle queue.
  - Required: `TxD_start` high only in the cycle after E1, with `TxD_data`=0xA5.
  - Required: after busy falls, `sent` pulses once and `sent_count`=1.
  - Required: the bench receiver reports 0xA5.
- Overflow, DEPTH_LOG=4, transmitter held busy:
  - Stimulus: push 17 bytes, 0x00..0x10.
  - Required: `full`=1 after 16 pushes and `overflow`=1 after the 17th.
  - Required: after release, exactly 0x00..0x0F are sent in order and `sent_count`=16.
- Wrap-around:
  - Stimulus: stream 40 bytes, 0x30..0x57, pushed whenever `full`=0.
  - Required: the receiver sees 0x30..0x57 in order and `sent_count`=40.
  - Required: `overflow` stays 0.
- Gap, GAP_CYCLES=5:
  - Stimulus: two queued bytes.
  - Required: the second `TxD_start` is asserted exactly 6 cycles after the first `sent`.
- Stall:
  - Stimulus: hold `TxD_busy`=0 with no transmitter attached; push 0x11 and 0x22.
  - Required: each byte sets or keeps `tx_stall`=1 after STALL_LIMIT=4 cycles in WAIT_BUSY.
  - Required: no `sent` pulse, `sent_count`=0, and the queue drains to `empty`=1.
- Reset mid-operation:
  - Stimulus: assert `rst` for 1 cycle while in WAIT_DONE with 3 bytes queued.
  - Required: every output returns to its reset value at that edge.
  - Required: no further `TxD_start` until `TxD_busy`=0 and a new push arrives.
